// File: rtl/interrupt_pending_ctrl.sv
// Interrupt pending/enable controller: synchronizes raw sources, holds the pending and
// enable registers, and hands a frozen masked snapshot to the trap unit over a valid/ack handshake.

module interrupt_pending_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic src,
  output logic lvl,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sq;
  logic                   prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sq   <= '0;
      prev <= 1'b0;
    end else begin
      sq   <= {sq[SYNC_STAGES-2:0], src};
      prev <= sq[SYNC_STAGES-1];
    end
  end

  assign lvl  = sq[SYNC_STAGES-1];
  assign rise = lvl & ~prev;
endmodule

module interrupt_pending_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [5:0] EDGE_MASK   = 6'b000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  irq_src,
  input  logic        global_ie,
  input  logic        csr_we,
  input  logic        csr_sel,
  input  logic [15:0] csr_wdata,
  output logic [15:0] csr_rdata,
  output logic        irq_valid,
  output logic [15:0] irq_signal,
  input  logic        ack,
  input  logic [5:0]  ack_code,
  output logic        ack_err
);
  localparam int NUM_SRC = 6;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] COOL = 2'd2;

  logic [1:0]         state;
  logic [NUM_SRC-1:0] pending, enable, pend_nx;
  logic [NUM_SRC-1:0] lvl, rise, code_hot;
  logic               hit;
  logic               unused_wdata;

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_lane
      interrupt_pending_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
        .clk    (clk),
        .reset_n(reset_n),
        .src    (irq_src[g]),
        .lvl    (lvl[g]),
        .rise   (rise[g])
      );
      // source i is taken back as cause code 2i+1
      assign code_hot[g] = (ack_code == 6'(2*g+1));
    end
  endgenerate

  assign hit          = |(code_hot & irq_signal[NUM_SRC-1:0]);
  assign unused_wdata = ^csr_wdata[15:6];
  assign csr_rdata    = {10'b0, csr_sel ? enable : pending};

  // set beats clear; level bits simply mirror the synced source
  always_comb begin
    pend_nx = (csr_we && !csr_sel) ? csr_wdata[NUM_SRC-1:0] : pending;
    if (state == REQ && ack && hit)
      pend_nx = pend_nx & ~code_hot;
    pend_nx = pend_nx | rise;
    pend_nx = (pend_nx & EDGE_MASK) | (lvl & ~EDGE_MASK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      enable     <= '0;
      state      <= IDLE;
      irq_valid  <= 1'b0;
      irq_signal <= '0;
      ack_err    <= 1'b0;
    end else begin
      pending <= pend_nx;
      ack_err <= 1'b0;
      if (csr_we && csr_sel)
        enable <= csr_wdata[NUM_SRC-1:0];
      case (state)
        IDLE: if (global_ie && |(pending & enable)) begin
          irq_signal <= {10'b0, pending & enable};
          state      <= REQ;
          irq_valid  <= 1'b1;
        end
        REQ: if (ack) begin
          ack_err   <= !hit;
          state     <= COOL;
          irq_valid <= 1'b0;
        end else if (!global_ie) begin
          state     <= IDLE;
          irq_valid <= 1'b0;
        end
        COOL: state <= IDLE;
        default: begin
          state     <= IDLE;
          irq_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
